// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU with EX stall request
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  typedef enum logic [1:0] {FREE = 2'd0, BY_ZERO = 2'd1, ON = 2'd2, END = 2'd3} state_e;
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] dvd_q, dvs_q, rem_q, quot_q;
  logic              quot_neg_q, rem_neg_q;
  logic              op1_neg, op2_neg;
  logic [DATA_W-1:0] op1_abs, op2_abs, rem_d, quot_d, quot_fix, rem_fix;
  logic [DATA_W:0]   shift_w, diff_w;
  assign stallreq_o = start_i & ~ready_o & ~annul_i;
  // Operand magnitudes, one shift-subtract step, and final sign correction
  always_comb begin
    op1_neg  = signed_div_i & opdata1_i[DATA_W-1];
    op2_neg  = signed_div_i & opdata2_i[DATA_W-1];
    op1_abs  = op1_neg ? -opdata1_i : opdata1_i;
    op2_abs  = op2_neg ? -opdata2_i : opdata2_i;
    shift_w  = {rem_q, dvd_q[DATA_W-1]};
    diff_w   = shift_w - {1'b0, dvs_q};
    rem_d    = diff_w[DATA_W] ? shift_w[DATA_W-1:0] : diff_w[DATA_W-1:0];
    quot_d   = {quot_q[DATA_W-2:0], ~diff_w[DATA_W]};
    quot_fix = quot_neg_q ? -quot_q : quot_q;
    rem_fix  = rem_neg_q ? -rem_q : rem_q;
  end
  // Divider control FSM with registered result and ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FREE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_o   <= '0;
      ready_o    <= 1'b0;
    end else begin
      case (state_q)
        FREE: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state_q <= BY_ZERO;
            end else begin
              dvd_q      <= op1_abs;
              dvs_q      <= op2_abs;
              quot_neg_q <= op1_neg ^ op2_neg;
              rem_neg_q  <= op1_neg;
              cnt_q      <= '0;
              rem_q      <= '0;
              quot_q     <= '0;
              state_q    <= ON;
            end
          end else begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        BY_ZERO: begin
          state_q  <= annul_i ? FREE : END;
          result_o <= '0;
          ready_o  <= ~annul_i;
        end
        ON: begin
          if (annul_i) begin
            state_q  <= FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else if (cnt_q != CNT_W'(DATA_W)) begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvd_q  <= dvd_q << 1;
            cnt_q  <= cnt_q + 1'b1;
          end else begin
            result_o <= {rem_fix, quot_fix};
            ready_o  <= 1'b1;
            state_q  <= END;
          end
        end
        END: begin
          if (annul_i || !start_i) begin
            state_q  <= FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: state_q <= FREE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  always #5 clk = ~clk;
  div_unit dut (
    .clk(clk), .rst_n(rst_n), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .start_i(start_i),
    .annul_i(annul_i), .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
  );
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    sa = s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = s ? longint'($signed(b)) : longint'({32'd0, b});
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, input int hold);
    int cyc;
    logic got;
    logic [63:0] e;
    @(negedge clk);
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
    exp_q.push_back(model(s, a, b));
    #1 chk("stall_start", 64'(stallreq_o), 64'd1);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~s;
      end
      if (ready_o) got = 1'b1;
      else if (cyc == 5) chk("stall_mid", 64'(stallreq_o), 64'd1);
    end
    chk("ready_seen", 64'(got), 64'd1);
    e = exp_q.pop_front();
    chk("latency", 64'(cyc - 1), (b == 32'd0) ? 64'd1 : 64'd33);
    chk("result", result_o, e);
    chk("stall_at_ready", 64'(stallreq_o), 64'd0);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_ready", 64'(ready_o), 64'd1);
      chk("hold_result", result_o, e);
    end
    start_i = 1'b0;
    @(negedge clk);
    chk("clr_ready", 64'(ready_o), 64'd0);
    chk("clr_result", result_o, 64'd0);
  endtask
  initial begin
    logic seen;
    int   k;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    rst_n = 1'b1;
    run_op(1'b0, 32'd100, 32'd7, 0);
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 0);
    run_op(1'b1, 32'd7, 32'hFFFFFFFE, 0);
    run_op(1'b1, 32'd5, 32'd0, 0);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(1'b0, 32'd0, 32'd13, 0);
    run_op(1'b0, 32'hFFFFFFFF, 32'd1, 1);
    run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 0);
    // annul while iterating at cnt 10
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    #1 chk("annul_stall", 64'(stallreq_o), 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    chk("annul_ready", 64'(ready_o), 64'd0);
    chk("annul_result", result_o, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= ready_o;
    end
    chk("annul_no_ready", 64'(seen), 64'd0);
    run_op(1'b0, 32'd9, 32'd3, 5);
    // annul in divide-by-zero state
    @(negedge clk);
    opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    chk("byzero_annul_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    chk("byzero_annul_ready2", 64'(ready_o), 64'd0);
    // async reset at cnt 20
    @(negedge clk);
    opdata1_i = 32'd12345; opdata2_i = 32'd17; start_i = 1'b1;
    repeat (21) @(negedge clk);
    rst_n = 1'b0; start_i = 1'b0;
    #1 chk("midrst_ready", 64'(ready_o), 64'd0);
    chk("midrst_result", result_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= ready_o;
    end
    chk("midrst_no_ready", 64'(seen), 64'd0);
    // async reset while a result is being held
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd6; opdata2_i = 32'd2; start_i = 1'b1;
    k = 0;
    while (!ready_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("endrst_pre_ready", 64'(ready_o), 64'd1);
    rst_n = 1'b0;
    #1 chk("endrst_ready", 64'(ready_o), 64'd0);
    chk("endrst_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 32'd12345, 32'd17, 2);
    run_op(1'b1, 32'hFFFFCFC7, 32'd17, 0);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 5 == 4) ? 32'd0 : ($urandom >> ($urandom % 32));
      run_op(1'($urandom % 2), a, b, int'($urandom % 3));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
